// File: rtl/iomem_gpio_pkg.sv
// Shared constants for the iomem GPIO block: bus select value, register offsets
// and the byte-strobe expansion helper.
package iomem_gpio_pkg;

  localparam logic [7:0] GPIO_ADDR_HI_DEFAULT = 8'h03;

  localparam logic [7:0] GPIO_OUT     = 8'h00;
  localparam logic [7:0] GPIO_OE      = 8'h04;
  localparam logic [7:0] GPIO_IN      = 8'h08;
  localparam logic [7:0] GPIO_IRQ_EN  = 8'h0C;
  localparam logic [7:0] GPIO_IRQ_POL = 8'h10;
  localparam logic [7:0] GPIO_PEND    = 8'h14;
  localparam logic [7:0] GPIO_OUT_SET = 8'h18;
  localparam logic [7:0] GPIO_OUT_CLR = 8'h1C;

  // Word indices: the decoder ignores address bits [1:0].
  localparam logic [5:0] W_OUT     = GPIO_OUT[7:2];
  localparam logic [5:0] W_OE      = GPIO_OE[7:2];
  localparam logic [5:0] W_IN      = GPIO_IN[7:2];
  localparam logic [5:0] W_IRQ_EN  = GPIO_IRQ_EN[7:2];
  localparam logic [5:0] W_IRQ_POL = GPIO_IRQ_POL[7:2];
  localparam logic [5:0] W_PEND    = GPIO_PEND[7:2];
  localparam logic [5:0] W_OUT_SET = GPIO_OUT_SET[7:2];
  localparam logic [5:0] W_OUT_CLR = GPIO_OUT_CLR[7:2];

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/iomem_gpio_if.sv
// PicoSoC iomem bus bundle; master = CPU side, slave = peripheral side.
interface iomem_gpio_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_gpio_sync.sv
// Two-flop synchroniser bringing asynchronous pad inputs into the clk domain.
module gpio_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/iomem_gpio.sv
// GPIO peripheral on the PicoSoC iomem bus: OUT/OE/IN, atomic set/clear and,
// when IOMEM_GPIO_IRQ_EN is defined, edge-detect interrupts (IRQ_EN/IRQ_POL/PEND).
module iomem_gpio
  import iomem_gpio_pkg::*;
#(
  parameter int         WIDTH   = 32,
  parameter logic [7:0] ADDR_HI = GPIO_ADDR_HI_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  iomem_gpio_if.slave      bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic             r_ready;
  logic [31:0]      r_rdata;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_oe;
  logic [WIDTH-1:0] w_in_sync;

  logic             w_hit;
  logic             w_wr;
  logic [5:0]       w_word;
  logic [31:0]      w_mask32;
  logic [31:0]      w_wdata_m32;
  logic [WIDTH-1:0] w_wmask;
  logic [WIDTH-1:0] w_wbits;
  logic [31:0]      w_rd;
  logic             w_unused_bits;

  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (gpio_in),
    .o_q   (w_in_sync)
  );

  // Blocking on r_ready makes each access take exactly one ack cycle.
  assign w_hit       = bus.iomem_valid & ~r_ready & (bus.iomem_addr[31:24] == ADDR_HI);
  assign w_wr        = w_hit & (|bus.iomem_wstrb);
  assign w_word      = bus.iomem_addr[7:2];
  assign w_mask32    = strb_mask(bus.iomem_wstrb);
  assign w_wdata_m32 = bus.iomem_wdata & w_mask32;
  assign w_wmask     = w_mask32[WIDTH-1:0];
  assign w_wbits     = w_wdata_m32[WIDTH-1:0];

  assign w_unused_bits = ^{bus.iomem_addr[23:8], bus.iomem_addr[1:0], w_wdata_m32, w_mask32};

`ifdef IOMEM_GPIO_IRQ_EN
  logic [WIDTH-1:0] r_irq_en;
  logic [WIDTH-1:0] r_irq_pol;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] r_prev;
  logic             r_irq;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;

  assign w_rise = w_in_sync & ~r_prev;
  assign w_fall = ~w_in_sync & r_prev;
  assign w_edge = r_irq_en & ((r_irq_pol & w_rise) | (~r_irq_pol & w_fall));
  assign w_clr  = (w_wr && (w_word == W_PEND)) ? w_wbits : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_en  <= '0;
      r_irq_pol <= '0;
      r_pend    <= '0;
      r_prev    <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_prev <= w_in_sync;
      if (w_wr && (w_word == W_IRQ_EN))
        r_irq_en <= (r_irq_en & ~w_wmask) | w_wbits;
      if (w_wr && (w_word == W_IRQ_POL))
        r_irq_pol <= (r_irq_pol & ~w_wmask) | w_wbits;
      // An edge arriving with a W1C of the same bit keeps the bit pending.
      r_pend <= (r_pend & ~w_clr) | w_edge;
      r_irq  <= |(r_pend & r_irq_en);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    w_rd = '0;
    case (w_word)
      W_OUT:     w_rd[WIDTH-1:0] = r_out;
      W_OE:      w_rd[WIDTH-1:0] = r_oe;
      W_IN:      w_rd[WIDTH-1:0] = w_in_sync;
`ifdef IOMEM_GPIO_IRQ_EN
      W_IRQ_EN:  w_rd[WIDTH-1:0] = r_irq_en;
      W_IRQ_POL: w_rd[WIDTH-1:0] = r_irq_pol;
      W_PEND:    w_rd[WIDTH-1:0] = r_pend;
`endif
      default:   w_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_out   <= '0;
      r_oe    <= '0;
    end else begin
      r_ready <= w_hit;
      if (w_hit)
        r_rdata <= w_rd;
      if (w_wr && (w_word == W_OUT))
        r_out <= (r_out & ~w_wmask) | w_wbits;
      else if (w_wr && (w_word == W_OUT_SET))
        r_out <= r_out | w_wbits;
      else if (w_wr && (w_word == W_OUT_CLR))
        r_out <= r_out & ~w_wbits;
      if (w_wr && (w_word == W_OE))
        r_oe <= (r_oe & ~w_wmask) | w_wbits;
    end
  end

  assign bus.iomem_ready = r_ready;
  assign bus.iomem_rdata = r_rdata;
  assign gpio_out        = r_out;
  assign gpio_oe         = r_oe;

endmodule
